// File: rtl/pic_pkg.sv
// Shared encodings for the PIC priority resolver: OCW2-style priority modes
// and the request/acknowledge handshake states.
package pic_pkg;

    typedef enum logic [1:0] {
        PR_FIXED    = 2'b00,
        PR_AUTO     = 2'b01,
        PR_SPECIFIC = 2'b10,
        PR_RESERVED = 2'b11
    } pr_mode_e;

    typedef enum logic [1:0] {
        PR_IDLE,
        PR_REQ,
        PR_WAIT
    } pr_state_e;

endpackage

// File: rtl/pr_circular_scan.sv
// Combinational rotating-priority scan: the lowest-rank candidate starting at base,
// blocked by any in-service line of equal or higher priority.
module pr_circular_scan
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] candidates,
    input  logic [NUM_IRQ-1:0] isr,
    input  logic [IDX_W-1:0]   base,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic             blocked;
    int unsigned      idx;
    logic [IDX_W-1:0] sel;

    always_comb begin
        found   = 1'b0;
        blocked = 1'b0;
        winner  = '0;
        idx     = 0;
        sel     = '0;
        // Walk ranks 0..N-1; an ISR bit at the same rank blocks before the candidate is taken.
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            idx = 32'(base) + k;
            if (idx >= NUM_IRQ) begin
                idx = idx - NUM_IRQ;
            end
            sel = idx[IDX_W-1:0];
            if (!found && !blocked) begin
                if (isr[sel]) begin
                    blocked = 1'b1;
                end else if (candidates[sel]) begin
                    found  = 1'b1;
                    winner = sel;
                end
            end
        end
    end

endmodule

// File: rtl/priority_resolver_rot.sv
// 8259A-style priority resolver with fixed, automatic and specific rotation, and a
// registered 4-phase request/acknowledge handshake towards the INTA sequencer.
module priority_resolver_rot
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic [NUM_IRQ-1:0] isr,
    input  logic               eoi_valid,
    input  logic [IDX_W-1:0]   eoi_index,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_mode,
    input  logic [IDX_W-1:0]   cmd_level,
    input  logic               freezing,
    input  logic               int_ack,
    output logic               int_req,
    output logic [IDX_W-1:0]   serviced_index,
    output logic [IDX_W-1:0]   zero_level_index
);

    pr_mode_e         mode_q, mode_d, cmd_m;
    pr_state_e        state_q, state_d;
    logic [IDX_W-1:0] base_q, base_d;
    logic             req_d;
    logic [IDX_W-1:0] idx_d;
    logic             found;
    logic [IDX_W-1:0] winner;

    function automatic logic in_range(input logic [IDX_W-1:0] v);
        return 32'(v) < NUM_IRQ;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (32'(v) + 1 >= NUM_IRQ) begin
            return '0;
        end
        return IDX_W'(32'(v) + 1);
    endfunction

    pr_circular_scan #(.NUM_IRQ(NUM_IRQ)) u_scan (
        .candidates (irr & ~imr),
        .isr        (isr),
        .base       (base_q),
        .found      (found),
        .winner     (winner)
    );

    // A valid command takes precedence over a same-cycle EOI rotation.
    always_comb begin
        mode_d = mode_q;
        base_d = base_q;
        cmd_m  = pr_mode_e'(cmd_mode);
        if (cmd_valid && cmd_m != PR_RESERVED) begin
            mode_d = cmd_m;
            if (cmd_m == PR_FIXED) begin
                base_d = '0;
            end else if (cmd_m == PR_SPECIFIC && in_range(cmd_level)) begin
                base_d = wrap_inc(cmd_level);
            end
        end else if (mode_q == PR_FIXED) begin
            base_d = '0;
        end else if (mode_q == PR_AUTO && eoi_valid && in_range(eoi_index)) begin
            base_d = wrap_inc(eoi_index);
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = int_req;
        idx_d   = serviced_index;
        unique case (state_q)
            PR_IDLE: begin
                if (found && !freezing) begin
                    idx_d   = winner;
                    req_d   = 1'b1;
                    state_d = PR_REQ;
                end
            end
            PR_REQ: begin
                if (int_ack) begin
                    req_d   = 1'b0;
                    state_d = PR_WAIT;
                end
            end
            PR_WAIT: begin
                if (!int_ack) begin
                    state_d = PR_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = PR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q         <= PR_FIXED;
            base_q         <= '0;
            state_q        <= PR_IDLE;
            int_req        <= 1'b0;
            serviced_index <= '0;
        end else begin
            mode_q         <= mode_d;
            base_q         <= base_d;
            state_q        <= state_d;
            int_req        <= req_d;
            serviced_index <= idx_d;
        end
    end

    assign zero_level_index = base_q;

endmodule

// File: tb/tb_priority_resolver_rot.sv
// Bench for priority_resolver_rot: rank-based reference model checked every cycle
// on an 8-line instance, plus literal expectations on 8-line and 5-line instances.
module tb_priority_resolver_rot;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 8-line instance
    logic [7:0] irr, imr, isr;
    logic       eoi_valid, cmd_valid, freezing, int_ack;
    logic [2:0] eoi_index, cmd_level;
    logic [1:0] cmd_mode;
    logic       int_req;
    logic [2:0] serviced_index, zero_level_index;

    // 5-line instance
    logic [4:0] f_irr, f_imr, f_isr;
    logic       f_eoi_valid, f_cmd_valid, f_freezing, f_int_ack;
    logic [2:0] f_eoi_index, f_cmd_level;
    logic [1:0] f_cmd_mode;
    logic       f_int_req;
    logic [2:0] f_serviced_index, f_zero_level_index;

    priority_resolver_rot #(.NUM_IRQ(8)) dut8 (
        .clk(clk), .reset(reset), .irr(irr), .imr(imr), .isr(isr),
        .eoi_valid(eoi_valid), .eoi_index(eoi_index),
        .cmd_valid(cmd_valid), .cmd_mode(cmd_mode), .cmd_level(cmd_level),
        .freezing(freezing), .int_ack(int_ack), .int_req(int_req),
        .serviced_index(serviced_index), .zero_level_index(zero_level_index)
    );

    priority_resolver_rot #(.NUM_IRQ(5)) dut5 (
        .clk(clk), .reset(reset), .irr(f_irr), .imr(f_imr), .isr(f_isr),
        .eoi_valid(f_eoi_valid), .eoi_index(f_eoi_index),
        .cmd_valid(f_cmd_valid), .cmd_mode(f_cmd_mode), .cmd_level(f_cmd_level),
        .freezing(f_freezing), .int_ack(f_int_ack), .int_req(f_int_req),
        .serviced_index(f_serviced_index), .zero_level_index(f_zero_level_index)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: priority by rank distance from base, nesting by lowest ISR rank.
    int m_mode, m_base, m_idx, m_phase;
    bit m_req;

    function automatic int model_winner(input logic [7:0] c, input logic [7:0] s, input int b);
        int best = 99;
        int blk  = 99;
        int who  = -1;
        int r;
        for (int i = 0; i < 8; i++) begin
            r = (i - b + 8) % 8;
            if (s[i] && r < blk) blk = r;
            if (c[i] && r < best) begin
                best = r;
                who  = i;
            end
        end
        return (best < blk) ? who : -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_mode = 0; m_base = 0; m_idx = 0; m_phase = 0; m_req = 1'b0;
        end else begin
            w = model_winner(irr & ~imr, isr, m_base);
            case (m_phase)
                0: if (w >= 0 && !freezing) begin m_idx = w; m_req = 1'b1; m_phase = 1; end
                1: if (int_ack) begin m_req = 1'b0; m_phase = 2; end
                default: if (!int_ack) m_phase = 0;
            endcase
            if (cmd_valid && cmd_mode != 2'd3) begin
                m_mode = int'(cmd_mode);
                if (cmd_mode == 2'd0) m_base = 0;
                else if (cmd_mode == 2'd2) m_base = (int'(cmd_level) + 1) % 8;
            end else if (eoi_valid && m_mode == 1) begin
                m_base = (int'(eoi_index) + 1) % 8;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_int_req", int_req, m_req);
            check("cmp_serviced", serviced_index, m_idx);
            check("cmp_zero_level", zero_level_index, m_base);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        irr = '0; imr = '0; isr = '0; eoi_valid = 0; eoi_index = '0;
        cmd_valid = 0; cmd_mode = '0; cmd_level = '0; freezing = 0; int_ack = 0;
        f_irr = '0; f_imr = '0; f_isr = '0; f_eoi_valid = 0; f_eoi_index = '0;
        f_cmd_valid = 0; f_cmd_mode = '0; f_cmd_level = '0; f_freezing = 0; f_int_ack = 0;
        step(2);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_int_req", int_req, 0);
        check("rst_serviced", serviced_index, 0);
        check("rst_zero_level", zero_level_index, 0);

        // Fixed mode
        irr = 8'b1010_0000; step(1);
        check("fix_req", int_req, 1);
        check("fix_serviced", serviced_index, 5);
        check("fix_zero", zero_level_index, 0);
        irr = 8'h80; step(1);
        check("fix_hold_idx", serviced_index, 5);
        int_ack = 1; step(1);
        check("fix_ack_drop", int_req, 0);
        int_ack = 0; irr = '0; step(1);

        // Automatic rotation
        cmd_valid = 1; cmd_mode = 2'b01; step(1); cmd_valid = 0;
        eoi_valid = 1; eoi_index = 3'd4; step(1); eoi_valid = 0;
        check("auto_zero5", zero_level_index, 5);
        irr = 8'b0010_0001; step(1);
        check("auto_req", int_req, 1);
        check("auto_serviced", serviced_index, 5);
        int_ack = 1; irr = '0; step(1); int_ack = 0; step(1);
        eoi_valid = 1; eoi_index = 3'd7; step(1); eoi_valid = 0;
        check("auto_wrap", zero_level_index, 0);

        // Specific rotation and nesting
        cmd_valid = 1; cmd_mode = 2'b10; cmd_level = 3'd2; step(1); cmd_valid = 0;
        check("spec_zero3", zero_level_index, 3);
        irr = 8'b0000_0101; step(1);
        check("spec_serviced", serviced_index, 0);
        int_ack = 1; irr = '0; step(1); int_ack = 0; step(1);
        isr = 8'b0100_0000; irr = 8'b1000_0000; step(3);
        check("spec_nest_block", int_req, 0);
        eoi_valid = 1; eoi_index = 3'd1; step(1); eoi_valid = 0;
        check("spec_no_eoi_rot", zero_level_index, 3);
        isr = '0; step(1);
        check("spec_unblock_idx", serviced_index, 7);
        int_ack = 1; irr = '0; step(1); int_ack = 0; step(1);

        // Freeze
        freezing = 1; cmd_valid = 1; cmd_mode = 2'b00; step(1); cmd_valid = 0;
        irr = 8'h01; step(2);
        check("frz_hold", int_req, 0);
        freezing = 0; step(1);
        check("frz_release", int_req, 1);
        freezing = 1; step(1); freezing = 0; irr = 8'h02; step(1);
        check("frz_in_req", serviced_index, 0);
        int_ack = 1; irr = '0; step(1); int_ack = 0; step(1);

        // Collision and reset mid-handshake
        cmd_valid = 1; cmd_mode = 2'b01; step(1); cmd_valid = 0;
        eoi_valid = 1; eoi_index = 3'd5; step(1); eoi_valid = 0;
        check("coll_pre", zero_level_index, 6);
        cmd_valid = 1; cmd_mode = 2'b00; eoi_valid = 1; eoi_index = 3'd3; step(1);
        cmd_valid = 0; eoi_valid = 0;
        check("coll_cmd_wins", zero_level_index, 0);
        irr = 8'h10; step(1);
        check("rst_mid_pre", serviced_index, 4);
        reset = 1; step(1);
        check("rst_mid_req", int_req, 0);
        check("rst_mid_idx", serviced_index, 0);
        reset = 0; irr = '0; int_ack = 1; step(1);
        irr = 8'h08; step(1);
        check("stale_ack_launch", int_req, 1);
        step(1);
        check("stale_ack_drop", int_req, 0);
        int_ack = 0; irr = '0; step(2);

        // Five lines: explicit modulo wrap and out-of-range operands
        f_cmd_valid = 1; f_cmd_mode = 2'b01; step(1); f_cmd_valid = 0;
        f_eoi_valid = 1; f_eoi_index = 3'd2; step(1);
        check("n5_eoi2", f_zero_level_index, 3);
        f_eoi_index = 3'd4; step(1);
        check("n5_wrap", f_zero_level_index, 0);
        f_eoi_index = 3'd5; step(1); f_eoi_valid = 0;
        check("n5_eoi_oor", f_zero_level_index, 0);
        f_cmd_valid = 1; f_cmd_mode = 2'b10; f_cmd_level = 3'd1; step(1);
        check("n5_spec", f_zero_level_index, 2);
        f_cmd_level = 3'd6; step(1); f_cmd_valid = 0;
        check("n5_level_oor", f_zero_level_index, 2);
        f_irr = 5'b00011; step(1);
        check("n5_req", f_int_req, 1);
        check("n5_serviced", f_serviced_index, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
